pool_fmap_flattener: RTL

// - Sits directly downstream of the 2x2 max-pooling stage; consumes its pooled-row stream
//   (one row of ROW_W FP16 values per input_valid pulse, no back-pressure possible).
// - Collects NUM_ROWS rows into a complete feature map, then streams the map out one FP16

---
 rtl/cnn_pkg.sv | 16 +
 rtl/fmap_bank.sv | 32 +++
 rtl/pool_fmap_flattener.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: FP16 element, pooled-map geometry and the bank states.
package cnn_pkg;

  localparam int FP16_W     = 16;
  localparam int POOL_ROW_W = 12;
  localparam int POOL_ROWS  = 12;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/fmap_bank.sv
// One feature-map buffer: whole-row writes from pooling, single-element reads towards FC.
module fmap_bank
  import cnn_pkg::*;
#(
  parameter  int ROW_W     = POOL_ROW_W,
  parameter  int NUM_ROWS  = POOL_ROWS,
  parameter  int DATA_W    = FP16_W,
  localparam int ROW_IDX_W = $clog2(NUM_ROWS),
  localparam int COL_W     = $clog2(ROW_W)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ROW_IDX_W-1:0]    wr_row,
  input  logic [ROW_W*DATA_W-1:0] wr_data,
  input  logic [ROW_IDX_W-1:0]    rd_row,
  input  logic [COL_W-1:0]        rd_col,
  output logic [DATA_W-1:0]       rd_data
);

  // Storage is deliberately not reset; the bank state in the top qualifies its contents.
  logic [ROW_W-1:0][DATA_W-1:0] mem_r [NUM_ROWS];

  // Row write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_row] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_row][rd_col];

endmodule

// File: rtl/pool_fmap_flattener.sv
// Ping-pong row collector that flattens each pooled feature map into a row-major element stream.
module pool_fmap_flattener
  import cnn_pkg::*;
#(
  parameter  int ROW_W    = POOL_ROW_W,
  parameter  int NUM_ROWS = POOL_ROWS,
  parameter  int DATA_W   = FP16_W,
  localparam int IDX_W    = $clog2(ROW_W*NUM_ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ROW_W*DATA_W-1:0] in_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [IDX_W-1:0]        out_index,
  output logic                    overflow
);

  localparam int ROW_IDX_W = $clog2(NUM_ROWS);
  localparam int COL_W     = $clog2(ROW_W);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS-1);
  localparam logic [COL_W-1:0]     LAST_COL = COL_W'(ROW_W-1);

  bank_state_e            bank_state_r [2];
  logic                   wr_bank_r;
  logic [ROW_IDX_W-1:0]   wr_row_r;
  logic                   rd_bank_r;
  logic [ROW_IDX_W-1:0]   rd_row_r;
  logic [COL_W-1:0]       rd_col_r;
  logic [IDX_W-1:0]       rd_idx_r;
  logic                   overflow_r;

  logic                   wr_ok_s;
  logic                   wr_last_s;
  logic                   rd_valid_s;
  logic                   rd_at_last_s;
  logic                   beat_s;
  logic                   drain_done_s;
  logic [DATA_W-1:0]      bank_rd_data_s [2];

  // Write acceptance and read handshake decode, all from pre-edge register state
  always_comb begin
    wr_ok_s      = 1'b0;
    wr_last_s    = 1'b0;
    rd_valid_s   = 1'b0;
    rd_at_last_s = 1'b0;
    beat_s       = 1'b0;
    drain_done_s = 1'b0;
    if (in_valid && (bank_state_r[wr_bank_r] != BANK_FULL)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
    wr_last_s    = wr_ok_s && (wr_row_r == LAST_ROW);
    rd_valid_s   = (bank_state_r[rd_bank_r] == BANK_FULL);
    rd_at_last_s = (rd_row_r == LAST_ROW) && (rd_col_r == LAST_COL);
    beat_s       = rd_valid_s && out_ready;
    drain_done_s = beat_s && rd_at_last_s;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank #(
      .ROW_W   (ROW_W),
      .NUM_ROWS(NUM_ROWS),
      .DATA_W  (DATA_W)
    ) u_bank (
      .clk    (clk),
      .wr_en  (wr_ok_s && (wr_bank_r == 1'(b))),
      .wr_row (wr_row_r),
      .wr_data(in_row),
      .rd_row (rd_row_r),
      .rd_col (rd_col_r),
      .rd_data(bank_rd_data_s[b])
    );
  end

  // Per-bank lifecycle; a write and a drain never target the same bank on one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_state_r[b] <= BANK_EMPTY;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_ok_s && (wr_bank_r == 1'(b))) begin
          bank_state_r[b] <= wr_last_s ? BANK_FULL : BANK_FILLING;
        end else if (drain_done_s && (rd_bank_r == 1'(b))) begin
          bank_state_r[b] <= BANK_EMPTY;
        end
      end
    end
  end

  // Write pointers; a row hitting a FULL bank is lost and flagged until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_r  <= 1'b0;
      wr_row_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        if (wr_last_s) begin
          wr_row_r  <= '0;
          wr_bank_r <= ~wr_bank_r;
        end else begin
          wr_row_r <= wr_row_r + 1'b1;
        end
      end
      if (in_valid && !wr_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Read pointers advance only on an accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_r <= 1'b0;
      rd_row_r  <= '0;
      rd_col_r  <= '0;
      rd_idx_r  <= '0;
    end else if (beat_s) begin
      if (rd_at_last_s) begin
        rd_bank_r <= ~rd_bank_r;
        rd_row_r  <= '0;
        rd_col_r  <= '0;
        rd_idx_r  <= '0;
      end else begin
        rd_idx_r <= rd_idx_r + 1'b1;
        if (rd_col_r == LAST_COL) begin
          rd_col_r <= '0;
          rd_row_r <= rd_row_r + 1'b1;
        end else begin
          rd_col_r <= rd_col_r + 1'b1;
        end
      end
    end
  end

  assign out_valid = rd_valid_s;
  assign out_data  = rd_valid_s ? bank_rd_data_s[rd_bank_r] : '0;
  assign out_last  = rd_valid_s && rd_at_last_s;
  assign out_index = rd_idx_r;
  assign overflow  = overflow_r;

endmodule
